// File: rtl/five_detector.sv
`default_nettype none
// ============================================================================
//  Module      : five_detector
//  Description : Checks whether the last move on a 16x16 board completes a
//                run of five stones of the mover's colour through that cell.
//                The board and move are latched at start. The move cell is
//                classified in one cycle. The block then walks up to 5 cells
//                on each side of the move in each of the four line directions,
//                one cell per cycle, and reports the result.
//  Ports       : Clck    - clock, rising edge
//                Reset   - synchronous active-high reset
//                board   - 16x16 cells, cell (x,y) at bits [x*2 + y*32 +: 2]
//                start   - request a check of (move_x, move_y), taken in IDLE
//                move_x  - x coordinate of the last move
//                move_y  - y coordinate of the last move
//                busy    - a check is in progress
//                done    - one-cycle pulse when the results are valid
//                win     - five in a row found through the move
//                winner  - stone code found at the move cell
//                win_dir - lowest-index winning direction
//                          0=+x, 1=+y, 2=(+x,+y), 3=(+x,-y)
//                max_run - longest run through the move over all directions
//  Macros      : FIVE_DET_EXACT_EN - when defined, only a run of exactly five
//                wins. Longer runs (overlines) do not win.
//  Revision    : 1.0 - initial release
// ============================================================================
module five_detector #(
   parameter logic [1:0] P1_CODE = 2'b01,
   parameter logic [1:0] P2_CODE = 2'b10
) (
   input  logic         Clck,
   input  logic         Reset,
   input  logic [511:0] board,
   input  logic         start,
   input  logic [3:0]   move_x,
   input  logic [3:0]   move_y,
   output logic         busy,
   output logic         done,
   output logic         win,
   output logic [1:0]   winner,
   output logic [1:0]   win_dir,
   output logic [3:0]   max_run
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] c_last_step = 3'd4;

   state_t         r_state;
   state_t         w_state_nx;

   logic [511:0]   r_board;
   logic [3:0]     r_mx;
   logic [3:0]     r_my;
   logic [1:0]     r_dir;      // direction being scanned
   logic           r_side;     // 0 = positive side, 1 = negative side
   logic [2:0]     r_step;     // cell offset minus one, 0..4
   logic [2:0]     r_cnt;      // matches counted so far on the current side
   logic           r_alive;    // every cell on this side matched so far
   logic [2:0]     r_pos;      // frozen positive-side count of this direction
   logic           r_win_acc;
   logic [1:0]     r_dir_acc;
   logic [3:0]     r_max_acc;

   logic [1:0]     w_move_cell;
   logic           w_is_stone;
   logic [5:0]     w_k;
   logic [5:0]     w_mx6;
   logic [5:0]     w_my6;
   logic           w_x_en;
   logic           w_y_en;
   logic           w_x_neg;
   logic           w_y_neg;
   logic [5:0]     w_x;
   logic [5:0]     w_y;
   logic           w_in_range;
   logic [1:0]     w_cell;
   logic           w_match;
   logic           w_side_alive;
   logic [2:0]     w_side_cnt;
   logic           w_hit;
   logic [2:0]     w_cnt_nx;
   logic [3:0]     w_run;
   logic           w_dir_win;
   logic           w_dir_end;
   logic           w_scan_last;

   assign w_move_cell = r_board[{r_my, r_mx, 1'b0} +: 2];
   assign w_is_stone  = (w_move_cell == P1_CODE) || (w_move_cell == P2_CODE);

   // Coordinates are formed in 6 bits so a step off either edge shows up in
   // bits [5:4] (overflow to 16..20 or underflow to 59..63) instead of
   // aliasing onto a neighbouring row.
   always_comb begin
      w_k          = {3'b000, r_step} + 6'd1;
      w_mx6        = {2'b00, r_mx};
      w_my6        = {2'b00, r_my};
      w_x_en       = (r_dir != 2'd1);
      w_y_en       = (r_dir != 2'd0);
      w_x_neg      = r_side;
      w_y_neg      = (r_dir == 2'd3) ^ r_side;
      w_x          = !w_x_en ? w_mx6 : (w_x_neg ? (w_mx6 - w_k) : (w_mx6 + w_k));
      w_y          = !w_y_en ? w_my6 : (w_y_neg ? (w_my6 - w_k) : (w_my6 + w_k));
      w_in_range   = (w_x[5:4] == 2'b00) && (w_y[5:4] == 2'b00);
      w_cell       = r_board[{w_y[3:0], w_x[3:0], 1'b0} +: 2];
      w_match      = w_in_range && (w_cell == winner);
      // The first step of a side starts a fresh count.
      w_side_alive = (r_step == 3'd0) | r_alive;
      w_side_cnt   = (r_step == 3'd0) ? 3'd0 : r_cnt;
      w_hit        = w_side_alive & w_match;
      w_cnt_nx     = w_side_cnt + {2'b00, w_hit};
      w_run        = 4'd1 + {1'b0, r_pos} + {1'b0, w_cnt_nx};
`ifdef FIVE_DET_EXACT_EN
      w_dir_win    = (w_run == 4'd5);
`else
      w_dir_win    = (w_run >= 4'd5);
`endif
      w_dir_end    = r_side && (r_step == c_last_step);
      w_scan_last  = w_dir_end && (r_dir == 2'd3);
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nx = CHECK;
         CHECK:   w_state_nx = w_is_stone ? SCAN : DONE;
         SCAN:    if (w_scan_last) w_state_nx = DONE;
         DONE:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clck) begin
      if (Reset) begin
         r_state   <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         win       <= 1'b0;
         winner    <= 2'b00;
         win_dir   <= 2'b00;
         max_run   <= 4'd0;
         r_dir     <= 2'd0;
         r_side    <= 1'b0;
         r_step    <= 3'd0;
         r_cnt     <= 3'd0;
         r_alive   <= 1'b0;
         r_pos     <= 3'd0;
         r_win_acc <= 1'b0;
         r_dir_acc <= 2'd0;
         r_max_acc <= 4'd0;
      end else begin
         r_state <= w_state_nx;
         done    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_board   <= board;
                  r_mx      <= move_x;
                  r_my      <= move_y;
                  busy      <= 1'b1;
                  win       <= 1'b0;
                  winner    <= 2'b00;
                  win_dir   <= 2'b00;
                  max_run   <= 4'd0;
                  r_dir     <= 2'd0;
                  r_side    <= 1'b0;
                  r_step    <= 3'd0;
                  r_win_acc <= 1'b0;
                  r_dir_acc <= 2'd0;
                  r_max_acc <= 4'd0;
               end
            end
            CHECK: begin
               if (w_is_stone) winner <= w_move_cell;
            end
            SCAN: begin
               r_cnt   <= w_cnt_nx;
               r_alive <= w_hit;
               if (r_step == c_last_step) begin
                  r_step <= 3'd0;
                  if (!r_side) begin
                     r_pos  <= w_cnt_nx;
                     r_side <= 1'b1;
                  end else begin
                     r_side <= 1'b0;
                     r_dir  <= r_dir + 2'd1;
                     if (w_run > r_max_acc) r_max_acc <= w_run;
                     // Directions are visited in ascending order, so the
                     // first winner seen is the lowest-index one.
                     if (w_dir_win && !r_win_acc) begin
                        r_win_acc <= 1'b1;
                        r_dir_acc <= r_dir;
                     end
                  end
               end else begin
                  r_step <= r_step + 3'd1;
               end
            end
            DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               win     <= r_win_acc;
               win_dir <= r_dir_acc;
               max_run <= r_max_acc;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_five_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_five_detector
//  Description : Directed bench for five_detector. Each started check pushes
//                its expected result and latency onto a queue. A monitor
//                pops the queue on every done pulse and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_five_detector;

   localparam logic [1:0] c_p1 = 2'b01;
   localparam logic [1:0] c_p2 = 2'b10;

   logic         Clck = 1'b0;
   logic         Reset;
   logic [511:0] board;
   logic         start;
   logic [3:0]   move_x;
   logic [3:0]   move_y;
   logic         busy;
   logic         done;
   logic         win;
   logic [1:0]   winner;
   logic [1:0]   win_dir;
   logic [3:0]   max_run;

   five_detector #(.P1_CODE(c_p1), .P2_CODE(c_p2)) dut (
      .Clck    (Clck),
      .Reset   (Reset),
      .board   (board),
      .start   (start),
      .move_x  (move_x),
      .move_y  (move_y),
      .busy    (busy),
      .done    (done),
      .win     (win),
      .winner  (winner),
      .win_dir (win_dir),
      .max_run (max_run)
   );

   always #5 Clck = ~Clck;

   int cyc = 0;
   always @(posedge Clck) cyc <= cyc + 1;

   typedef struct {
      string      tag;
      logic       win;
      logic [1:0] winner;
      logic [1:0] dir;
      logic [3:0] mr;
      int         lat;
      int         n_edge;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input int x, input int y, input logic [1:0] c);
      board[x*2 + y*32 +: 2] = c;
   endtask

   // Called at a negedge; the following posedge is edge N of the check.
   task automatic kick(input int x, input int y, input string tag, input logic w,
                       input logic [1:0] wn, input logic [1:0] dr,
                       input logic [3:0] mr, input int lat);
      exp_t e;
      e.tag = tag; e.win = w; e.winner = wn; e.dir = dr; e.mr = mr;
      e.lat = lat; e.n_edge = cyc + 1;
      q.push_back(e);
      move_x = 4'(x);
      move_y = 4'(y);
      start  = 1'b1;
      @(negedge Clck);
      start  = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (q.size() != 0 && k < 80) begin
         @(negedge Clck);
         k++;
      end
      check({tag, "_pending"}, 32'(q.size()), 32'd0);
      q.delete();
   endtask

   // Scoreboard side: every done pulse must match the oldest expectation.
   always @(negedge Clck) begin : monitor
      exp_t e;
      if (Reset === 1'b0 && done === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            e = q.pop_front();
            check({e.tag, "_win"},     {31'd0, win},     {31'd0, e.win});
            check({e.tag, "_winner"},  {30'd0, winner},  {30'd0, e.winner});
            check({e.tag, "_win_dir"}, {30'd0, win_dir}, {30'd0, e.dir});
            check({e.tag, "_max_run"}, {28'd0, max_run}, {28'd0, e.mr});
            check({e.tag, "_busy"},    {31'd0, busy},    32'd0);
            check({e.tag, "_latency"}, 32'(cyc - e.n_edge), 32'(e.lat));
         end
      end
   end

   initial begin
      int  n0;
      logic w_over;

      Reset  = 1'b1;
      start  = 1'b0;
      board  = '1;
      move_x = 4'd0;
      move_y = 4'd0;
      repeat (3) @(negedge Clck);
      check("rst_busy",    {31'd0, busy},    32'd0);
      check("rst_done",    {31'd0, done},    32'd0);
      check("rst_win",     {31'd0, win},     32'd0);
      check("rst_winner",  {30'd0, winner},  32'd0);
      check("rst_win_dir", {30'd0, win_dir}, 32'd0);
      check("rst_max_run", {28'd0, max_run}, 32'd0);
      Reset = 1'b0;
      @(negedge Clck);

      // Empty move cell: short path, done two edges after start.
      board = '1;
      kick(4, 6, "empty", 1'b0, 2'b00, 2'd0, 4'd0, 2);
      drain("empty");

      // Horizontal five, with stray starts mid-scan and in the DONE cycle.
      board = '1;
      for (int x = 3; x <= 7; x++) put(x, 6, c_p1);
      kick(5, 6, "h5", 1'b1, c_p1, 2'd0, 4'd5, 42);
      n0 = cyc;
      repeat (2) @(negedge Clck);
      check("h5_busy_mid",   {31'd0, busy},   32'd1);
      check("h5_winner_mid", {30'd0, winner}, {30'd0, c_p1});
      check("h5_win_mid",    {31'd0, win},    32'd0);
      move_x = 4'd0;
      move_y = 4'd0;
      board  = '1;
      start  = 1'b1;
      @(negedge Clck);
      start  = 1'b0;
      while (cyc < n0 + 41) @(negedge Clck);
      start = 1'b1;
      @(negedge Clck);
      start = 1'b0;
      repeat (3) @(negedge Clck);
      check("h5_hold_win",     {31'd0, win},     32'd1);
      check("h5_hold_max_run", {28'd0, max_run}, 32'd5);
      check("h5_hold_winner",  {30'd0, winner},  {30'd0, c_p1});
      check("h5_hold_done",    {31'd0, done},    32'd0);
      drain("h5");

      // Run against the right edge must not continue onto the next row.
      board = '1;
      for (int x = 12; x <= 15; x++) put(x, 2, c_p1);
      put(0, 3, c_p1);
      kick(15, 2, "nowrap", 1'b0, c_p1, 2'd0, 4'd4, 42);
      drain("nowrap");

      // Overline of six against the left edge.
`ifdef FIVE_DET_EXACT_EN
      w_over = 1'b0;
`else
      w_over = 1'b1;
`endif
      board = '1;
      for (int x = 0; x <= 5; x++) put(x, 0, c_p2);
      kick(2, 0, "over6", w_over, c_p2, 2'd0, 4'd6, 42);
      drain("over6");

      // Anti-diagonal five; board wiped after latch must not matter.
      board = '1;
      put(9, 1, c_p2); put(8, 2, c_p2); put(7, 3, c_p2); put(6, 4, c_p2); put(5, 5, c_p2);
      kick(7, 3, "diag", 1'b1, c_p2, 2'd3, 4'd5, 42);
      n0 = cyc;
      while (cyc < n0 + 4) @(negedge Clck);
      board = '1;
      drain("diag");

      // Two winning directions: lowest index reported.
      board = '1;
      for (int x = 5; x <= 9; x++) put(x, 8, c_p1);
      for (int y = 6; y <= 10; y++) put(7, y, c_p1);
      kick(7, 8, "cross", 1'b1, c_p1, 2'd0, 4'd5, 42);
      drain("cross");

      // Reset mid-scan aborts silently; a fresh check then completes.
      board = '1;
      for (int y = 11; y <= 15; y++) put(10, y, c_p1);
      move_x = 4'd10;
      move_y = 4'd15;
      start  = 1'b1;
      n0     = cyc + 1;
      @(negedge Clck);
      start  = 1'b0;
      while (cyc < n0 + 9) @(negedge Clck);
      Reset = 1'b1;
      @(negedge Clck);
      Reset = 1'b0;
      check("abort_busy",    {31'd0, busy},    32'd0);
      check("abort_done",    {31'd0, done},    32'd0);
      check("abort_winner",  {30'd0, winner},  32'd0);
      check("abort_max_run", {28'd0, max_run}, 32'd0);
      repeat (50) @(negedge Clck);
      kick(10, 15, "vert", 1'b1, c_p1, 2'd1, 4'd5, 42);
      drain("vert");

      repeat (3) @(negedge Clck);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/five_detector.md
FIVE_DETECTOR -- requirements
Module: five_detector

Interface
REQ-001 The block SHALL have parameter P1_CODE, default 2'b01: cell code for player 1 stone.
REQ-002 The block SHALL have parameter P2_CODE, default 2'b10: cell code for player 2 stone; every other code (incl. 2'b11 empty, 2'b00) is non-stone.
REQ-003 The block SHALL have port Clck, input, 1: sole clock, rising edge.
REQ-004 The block SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port board, input, 512: 16x16 board, cell (x,y) at bits [x*2 + y*32 +: 2].
REQ-006 The block SHALL have port start, input, 1: request check of the last move.
REQ-007 The block SHALL have ports move_x and move_y, input, 4 each: coordinates of the last move.
REQ-008 The block SHALL have port busy, output, 1: check in progress.
REQ-009 The block SHALL have port done, output, 1: single-cycle result-valid pulse.
REQ-010 The block SHALL have port win, output, 1: five-in-a-row found through (move_x, move_y).
REQ-011 The block SHALL have port winner, output, 2: stone code at the move cell.
REQ-012 The block SHALL have port win_dir, output, 2: winning direction; 0 = +x, 1 = +y, 2 = (+x,+y), 3 = (+x,-y).
REQ-013 The block SHALL have port max_run, output, 4: longest run through the move over all directions, 0..11.

Function
REQ-014 States SHALL be IDLE, CHECK, SCAN, DONE.
REQ-015 In IDLE, start=1 at edge N SHALL latch board, move_x and move_y, clear win/winner/win_dir/max_run, set busy=1, and enter CHECK.
REQ-016 In CHECK (edge N+1), a non-stone move cell SHALL go to DONE with win=0 and max_run=0; done=1 SHALL follow at edge N+2.
REQ-017 For a stone cell, CHECK SHALL load winner with that code and enter SCAN.
REQ-018 SCAN SHALL take exactly 40 cycles (edges N+2..N+41), one cell per cycle; per direction it SHALL visit 5 cells on the positive side, then 5 on the negative side, in order dir 0,1,2,3.
REQ-019 A side's count SHALL increment only while every cell visited so far on that side matches winner; the first mismatch or off-board step freezes that side.
REQ-020 Coordinates SHALL NOT wrap: a step outside 0..15 on either axis SHALL be a mismatch, never a read of the linearly adjacent bit pair.
REQ-021 Run for a direction SHALL be 1 + pos + neg (max 11); max_run SHALL track the maximum over directions.
REQ-022 win_dir SHALL be the lowest-index winning direction; it SHALL be 0 when win=0.
REQ-023 Results SHALL be registered at edge N+42 with done=1 and busy=0 for that one cycle, then return to IDLE.
REQ-024 Results SHALL hold until the next accepted start.
REQ-025 start while busy SHALL be ignored; board changes after edge N SHALL NOT affect the result.
REQ-026 start asserted in the DONE cycle SHALL be ignored; it is accepted only from IDLE.

Reset
REQ-027 Reset=1 at any edge, including mid-scan, SHALL force IDLE and busy=done=win=0, winner=win_dir=0, max_run=0; an aborted check SHALL produce no done pulse.

Configuration
REQ-028 With FIVE_DET_EXACT_EN defined, a direction SHALL win only if its run == 5 (overlines lose); without it, a direction SHALL win if its run >= 5.

Verification
REQ-029 All cells 2'b11, start at (4,6) -> done at N+2, win=0, max_run=0.
REQ-030 P1 stones at x=3..7, y=6, start at (5,6) -> done at N+42, win=1, winner=01, win_dir=0, max_run=5.
REQ-031 P1 stones at x=12..15, y=2 plus (0,3), start at (15,2) -> win=0, max_run=4 (no wrap).
REQ-032 P2 stones at x=0..5, y=0, start at (2,0) -> max_run=6; win=1 without FIVE_DET_EXACT_EN, win=0 with it.
REQ-033 P2 stones at (9,1),(8,2),(7,3),(6,4),(5,5), start at (7,3), board cleared at N+5 -> win=1, win_dir=3.
REQ-034 Reset at N+10 of a scan -> busy=0 next cycle, no done pulse; a new start then completes normally.
